// File: rtl/cpu_rd_arbiter_if.sv
// Read-cycle bus between the Z80 read strobe / chip-select decode and the read arbiter.
// The master side drives the strobe and raw selects; the slave side returns grant and status.
interface cpu_rd_arbiter_if #(
  parameter int unsigned N_SRC = 8
);
  logic             rd_req;
  logic [N_SRC-1:0] req;
  logic [N_SRC-1:0] grant;
  logic             wait_n;
  logic             rd_done;
  logic             conflict;
  logic             busy;

  modport master (
    output rd_req, req,
    input  grant, wait_n, rd_done, conflict, busy
  );

  modport slave (
    input  rd_req, req,
    output grant, wait_n, rd_done, conflict, busy
  );
endinterface

// File: rtl/cpu_rd_arbiter.sv
// Z80 read-cycle arbiter: latches one one-hot grant per read strobe and holds it until the
// strobe drops, stretching the cycle through WAIT_n for sources flagged as slow.
module cpu_rd_arbiter #(
  parameter int unsigned         N_SRC     = 8,
  parameter int unsigned         DEF_SRC   = 7,
  parameter logic [N_SRC-1:0]    SLOW_MASK = 8'b0110_0010,
  parameter int unsigned         WAIT_CYC  = 4
) (
  input  logic                pll0_250MHz,
  input  logic                reset,
  cpu_rd_arbiter_if.slave     bus
);

  localparam int unsigned      IDX_W     = $clog2(N_SRC);
  localparam logic [IDX_W-1:0] DEF_IDX   = IDX_W'(DEF_SRC);
  localparam logic [N_SRC-1:0] ONE       = {{(N_SRC-1){1'b0}}, 1'b1};
  localparam logic [N_SRC-1:0] ZERO      = {N_SRC{1'b0}};
  localparam logic             SLOW_EN   = (WAIT_CYC != 32'd0);
  localparam logic [7:0]       WAIT_LOAD = (WAIT_CYC == 32'd0) ? 8'd0 : 8'(WAIT_CYC - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [N_SRC-1:0] r_grant;
  logic             r_wait_n;
  logic             r_rd_done;
  logic             r_conflict;
  logic [7:0]       r_cnt;

  state_t           w_state_nx;
  logic [N_SRC-1:0] w_grant_nx;
  logic             w_wait_n_nx;
  logic             w_rd_done_nx;
  logic             w_conflict_nx;
  logic [7:0]       w_cnt_nx;
  logic [IDX_W-1:0] w_winner;
  logic [N_SRC-1:0] w_winner_oh;
  logic             w_winner_slow;

  // Lowest set bit wins; an empty select vector falls through to the default (bus) source.
  function automatic logic [IDX_W-1:0] f_winner(input logic [N_SRC-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = DEF_IDX;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // True when two or more selects are asserted together (clearing the lowest bit leaves some set).
  function automatic logic f_multi(input logic [N_SRC-1:0] v);
    return ((v & (v - ONE)) != ZERO);
  endfunction

  assign w_winner      = f_winner(bus.req);
  assign w_winner_oh   = ONE << w_winner;
  assign w_winner_slow = SLOW_MASK[w_winner] & SLOW_EN;

  // Next-state and next-output logic; pulses default low and everything else holds.
  always_comb begin
    w_state_nx    = r_state;
    w_grant_nx    = r_grant;
    w_wait_n_nx   = r_wait_n;
    w_rd_done_nx  = 1'b0;
    w_conflict_nx = 1'b0;
    w_cnt_nx      = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (bus.rd_req) begin
          w_grant_nx    = w_winner_oh;
          w_conflict_nx = f_multi(bus.req);
          if (w_winner_slow) begin
            w_wait_n_nx = 1'b0;
            w_cnt_nx    = WAIT_LOAD;
            w_state_nx  = ST_WAIT;
          end else begin
            w_wait_n_nx = 1'b1;
            w_cnt_nx    = 8'd0;
            w_state_nx  = ST_HOLD;
          end
        end else begin
          w_grant_nx  = ZERO;
          w_wait_n_nx = 1'b1;
          w_cnt_nx    = 8'd0;
        end
      end
      ST_WAIT: begin
        // A strobe that drops while stretched is an abort: release without rd_done.
        if (!bus.rd_req) begin
          w_grant_nx  = ZERO;
          w_wait_n_nx = 1'b1;
          w_cnt_nx    = 8'd0;
          w_state_nx  = ST_IDLE;
        end else if (r_cnt == 8'd0) begin
          w_wait_n_nx = 1'b1;
          w_state_nx  = ST_HOLD;
        end else begin
          w_cnt_nx = r_cnt - 8'd1;
        end
      end
      ST_HOLD: begin
        if (!bus.rd_req) begin
          w_grant_nx   = ZERO;
          w_rd_done_nx = 1'b1;
          w_state_nx   = ST_DONE;
        end else begin
          w_grant_nx = r_grant;
        end
      end
      ST_DONE: begin
        w_state_nx = ST_IDLE;
      end
      default: begin
        w_state_nx  = ST_IDLE;
        w_grant_nx  = ZERO;
        w_wait_n_nx = 1'b1;
        w_cnt_nx    = 8'd0;
      end
    endcase
  end

  // State and output registers; reset forces the idle outputs without waiting for a clock.
  always_ff @(posedge pll0_250MHz or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_grant    <= ZERO;
      r_wait_n   <= 1'b1;
      r_rd_done  <= 1'b0;
      r_conflict <= 1'b0;
      r_cnt      <= 8'd0;
    end else begin
      r_state    <= w_state_nx;
      r_grant    <= w_grant_nx;
      r_wait_n   <= w_wait_n_nx;
      r_rd_done  <= w_rd_done_nx;
      r_conflict <= w_conflict_nx;
      r_cnt      <= w_cnt_nx;
    end
  end

  assign bus.grant    = r_grant;
  assign bus.wait_n   = r_wait_n;
  assign bus.rd_done  = r_rd_done;
  assign bus.conflict = r_conflict;
  assign bus.busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_cpu_rd_arbiter.sv
// Scoreboard bench for cpu_rd_arbiter: a driver pushes the expected outcome of each read,
// a negedge monitor pops it when a grant appears and follows the cycle to its end.
module tb_cpu_rd_arbiter;

  localparam logic [7:0] B_SLOW = 8'b0110_0010;
  localparam int         B_WAIT = 4;
  localparam int         B_DEF  = 7;

  typedef struct {
    logic [7:0] grant;
    logic       conflict;
    int         hold;
    int         wait_len;
    logic       done;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  exp_t q[$];
  exp_t cur;
  bit   active;
  int   m_len;
  int   m_wait;

  cpu_rd_arbiter_if #(.N_SRC(8)) bus_if ();

  cpu_rd_arbiter dut (
    .pll0_250MHz (clk),
    .reset       (reset),
    .bus         (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference outcome of one read: which source, how long WAIT_n is low, whether it completes.
  function automatic exp_t model(input logic [7:0] r, input int h);
    exp_t e;
    int   w;
    bit   slow;
    w = B_DEF;
    for (int i = 7; i >= 0; i--) begin
      if (r[i]) w = i;
    end
    e.grant    = 8'd0;
    e.grant[w] = 1'b1;
    e.conflict = ($countones(r) > 1);
    slow       = B_SLOW[w] && (B_WAIT > 0);
    e.hold     = h;
    e.wait_len = slow ? ((h < B_WAIT) ? h : B_WAIT) : 0;
    e.done     = !(slow && (h <= B_WAIT));
    return e;
  endfunction

  // rd_req is sampled high on h consecutive edges (the first is the latch edge), then low.
  task automatic do_read(input logic [7:0] r, input int h, input int g,
                         input bit scr, input logic [7:0] mid);
    q.push_back(model(r, h));
    @(posedge clk); #1;
    bus_if.rd_req = 1'b1;
    bus_if.req    = r;
    for (int i = 0; i < h; i++) begin
      @(posedge clk); #1;
      if (scr) bus_if.req = mid;
    end
    bus_if.rd_req = 1'b0;
    bus_if.req    = 8'($urandom);
    repeat (g) @(posedge clk);
  endtask

  // Monitor: follows each granted cycle and compares it against the popped expectation.
  always @(negedge clk) begin
    if (reset) begin
      active = 1'b0;
    end else begin
      check("grant_onehot0", 32'($onehot0(bus_if.grant)), 32'd1);
      if (!active) begin
        if (bus_if.grant != 8'd0) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_grant: got %0h expected no grant", bus_if.grant);
          end else begin
            cur    = q.pop_front();
            active = 1'b1;
            m_len  = 1;
            m_wait = (bus_if.wait_n == 1'b0) ? 1 : 0;
            check("grant", 32'(bus_if.grant), 32'(cur.grant));
            check("conflict", 32'(bus_if.conflict), 32'(cur.conflict));
            check("busy_active", 32'(bus_if.busy), 32'd1);
            check("rd_done_at_latch", 32'(bus_if.rd_done), 32'd0);
          end
        end else begin
          check("idle_wait_n", 32'(bus_if.wait_n), 32'd1);
          check("idle_conflict", 32'(bus_if.conflict), 32'd0);
          check("idle_rd_done", 32'(bus_if.rd_done), 32'd0);
        end
      end else if (bus_if.grant != 8'd0) begin
        check("grant_stable", 32'(bus_if.grant), 32'(cur.grant));
        check("conflict_pulse", 32'(bus_if.conflict), 32'd0);
        check("rd_done_mid", 32'(bus_if.rd_done), 32'd0);
        check("busy_mid", 32'(bus_if.busy), 32'd1);
        m_len++;
        if (bus_if.wait_n == 1'b0) m_wait++;
      end else begin
        check("hold_len", 32'(m_len), 32'(cur.hold));
        check("wait_len", 32'(m_wait), 32'(cur.wait_len));
        check("rd_done_end", 32'(bus_if.rd_done), 32'(cur.done));
        check("busy_end", 32'(bus_if.busy), 32'(cur.done));
        check("wait_n_end", 32'(bus_if.wait_n), 32'd1);
        active = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "bench timeout");
  end

  initial begin
    total         = 0;
    bad           = 0;
    active        = 1'b0;
    reset         = 1'b0;
    bus_if.rd_req = 1'b0;
    bus_if.req    = 8'd0;
    #2 reset = 1'b1;
    #1;
    check("reset_grant", 32'(bus_if.grant), 32'd0);
    check("reset_wait_n", 32'(bus_if.wait_n), 32'd1);
    check("reset_rd_done", 32'(bus_if.rd_done), 32'd0);
    check("reset_conflict", 32'(bus_if.conflict), 32'd0);
    check("reset_busy", 32'(bus_if.busy), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);

    // T1: reset in the middle of a stretched read
    q.push_back(model(8'h20, 10));
    @(posedge clk); #1;
    bus_if.rd_req = 1'b1;
    bus_if.req    = 8'h20;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("t1_grant", 32'(bus_if.grant), 32'd0);
    check("t1_wait_n", 32'(bus_if.wait_n), 32'd1);
    check("t1_rd_done", 32'(bus_if.rd_done), 32'd0);
    bus_if.rd_req = 1'b0;
    q.delete();
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("t1_busy", 32'(bus_if.busy), 32'd0);
    repeat (2) @(posedge clk);

    do_read(8'h01, 5, 2, 1'b0, 8'h00);   // T2 fast source
    do_read(8'h20, 7, 2, 1'b0, 8'h00);   // T3 slow source, full wait
    do_read(8'h0A, 4, 2, 1'b1, 8'h08);   // T4 conflict, req changed mid-cycle
    do_read(8'h00, 6, 2, 1'b0, 8'h00);   // T5 default source
    do_read(8'h20, 2, 1, 1'b0, 8'h00);   // T6 abort inside WAIT
    do_read(8'h40, 4, 1, 1'b0, 8'h00);   // abort on the last wait cycle
    do_read(8'h04, 1, 1, 1'b0, 8'h00);   // shortest read, minimum spacing
    do_read(8'h02, 5, 1, 1'b0, 8'h00);   // shortest completing slow read

    for (int n = 0; n < 80; n++) begin
      logic [7:0] r;
      r = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      do_read(r, $urandom_range(1, 8), $urandom_range(1, 3), 1'b1, 8'($urandom));
    end

    repeat (5) @(posedge clk);
    check("queue_empty", 32'(q.size()), 32'd0);
    check("monitor_idle", 32'(active), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
